shift_sequencer: RTL and testbench

Controller that sequences an 8-bit right-shift register datapath for arithmetic and logical shifts by N.
- Accepts a job (operand, shift count, mode) over a valid/ready handshake.
- Loads the operand into the register and issues N single-bit shift cycles, filling the MSB with 0 (logical) or the sign bit (arithmetic).
- Presents the result and the last bit shifted out over a second valid/ready handshake.
- Sits between a command source (switches/keys or a CPU-side register) and any consumer of the shifted value.

---
 rtl/shift_sequencer_pkg.sv | 23 ++
 rtl/shift_sequencer_core.sv | 37 +++
 rtl/shift_sequencer.sv | 109 ++++++++++
 tb/tb_shift_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer.
// Holds state encodings, width defaults and the count saturation helper.
package shift_sequencer_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Shifting further than the width cannot change the result further.
    function automatic int sat_count(input int cnt, input int width);
        return (cnt > width) ? width : cnt;
    endfunction

endpackage

// File: rtl/shift_sequencer_core.sv
// Right-shift register with parallel load and external fill bit.
// Load wins over shift when both are requested.
module shift_reg_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (shift) begin
            q_d = {fill, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Sequences shift_reg_core through N logical or arithmetic right shifts.
// Jobs arrive and results leave over valid/ready; outputs are Moore.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;
    logic             carry_q;
    logic             carry_d;
    logic             mode_q;
    logic             mode_d;

    logic             load;
    logic             shift;
    logic             fill;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] sat_cnt;

    assign sat_cnt = CNT_W'(sat_count(int'(in_count), WIDTH));
    assign fill    = mode_q & q[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        carry_d     = carry_q;
        mode_d      = mode_q;
        load        = 1'b0;
        shift       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load        = 1'b1;
                    mode_d      = in_arith;
                    carry_d     = 1'b0;
                    remaining_d = sat_cnt;
                    state_d     = (sat_cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shift       = 1'b1;
                carry_d     = q[0];
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            carry_q     <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            carry_q     <= carry_d;
            mode_q      <= mode_d;
        end
    end

    shift_reg_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_data(in_data),
        .shift    (shift),
        .fill     (fill),
        .q        (q)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign out_data  = q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_shift_sequencer;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_count;
    logic       in_arith;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       busy;

    int passes = 0;
    int checks = 0;

    shift_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_count (in_count),
        .in_arith (in_arith),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Accept a job, confirm the wait cycles, stop on the first DONE cycle.
    task automatic run_job(input string tag,
                           input logic [7:0] data,
                           input logic [3:0] cnt,
                           input logic arith,
                           input logic [7:0] exp_data,
                           input logic exp_carry);
        int n;
        n = (cnt > 4'd8) ? 8 : int'(cnt);
        in_data  = data;
        in_count = cnt;
        in_arith = arith;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = ~data;
        in_count = 4'd15;
        in_arith = ~arith;
        for (int i = 0; i < n; i++) begin
            check({tag, " wait out_valid"}, 32'(out_valid), 32'd0);
            check({tag, " wait in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " wait busy"}, 32'(busy), 32'd1);
            tick();
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " out_data"}, 32'(out_data), 32'(exp_data));
        check({tag, " out_carry"}, 32'(out_carry), 32'(exp_carry));
        check({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_count  = 4'd3;
        in_arith  = 1'b0;
        out_ready = 1'b1;

        tick();
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b1;
        check_idle("reset");
        check("reset out_data", 32'(out_data), 32'h00);
        check("reset out_carry", 32'(out_carry), 32'd0);

        run_job("lsr2", 8'hB4, 4'd2, 1'b0, 8'h2D, 1'b0);
        tick();
        check_idle("lsr2 after");

        run_job("asr3 neg", 8'hB4, 4'd3, 1'b1, 8'hF6, 1'b1);
        tick();
        check_idle("asr3 neg after");

        run_job("asr3 pos", 8'h74, 4'd3, 1'b1, 8'h0E, 1'b1);
        tick();

        run_job("cnt0", 8'h5A, 4'd0, 1'b0, 8'h5A, 1'b0);
        tick();
        check_idle("cnt0 after");

        run_job("lsr9 sat", 8'hFF, 4'd9, 1'b0, 8'h00, 1'b1);
        tick();

        // 0x80 is already 0xFF after 7 sign-fill shifts, so shift 8 drops a 1.
        run_job("asr8", 8'h80, 4'd8, 1'b1, 8'hFF, 1'b1);
        tick();

        out_ready = 1'b0;
        run_job("bp", 8'h81, 4'd1, 1'b0, 8'h40, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_count = 4'd0;
        in_arith = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp hold out_valid", 32'(out_valid), 32'd1);
            check("bp hold out_data", 32'(out_data), 32'h40);
            check("bp hold out_carry", 32'(out_carry), 32'd1);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_idle("bp release");
        check("bp retained data", 32'(out_data), 32'h40);

        run_job("bp next", 8'h5A, 4'd0, 1'b0, 8'h5A, 1'b0);
        tick();
        check_idle("bp next after");

        in_data  = 8'hFF;
        in_count = 4'd6;
        in_arith = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst mid busy", 32'(busy), 32'd1);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_idle("rst mid");
        check("rst mid out_data", 32'(out_data), 32'h00);
        check("rst mid out_carry", 32'(out_carry), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("rst mid no result", 32'(out_valid), 32'd0);
            tick();
        end

        run_job("post rst", 8'h96, 4'd4, 1'b1, 8'hF9, 1'b0);
        tick();
        check_idle("post rst after");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
